// File: rtl/fp_unpack_align.sv
// FP add/sub front-end: unpacks two single-precision operands, classifies specials,
// orders by magnitude and right-aligns the smaller mantissa with guard/round/sticky.
module fp_unpack_align #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_result,
  output logic [26:0] mant_a,
  output logic [26:0] mant_b,
  output logic        sign_result,
  output logic        eff_sub,
  output logic        special,
  output logic [31:0] special_value
);

  // state  | meaning
  // IDLE   | waiting for operands, in_ready = 1
  // UNPACK | classify, swap, compute exponent difference
  // ALIGN  | shift smaller mantissa right, up to SHIFT_STEP per cycle
  // DONE   | results valid, held until out_ready
  typedef enum logic [1:0] {IDLE, UNPACK, ALIGN, DONE} state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t state, state_nxt;

  logic [31:0] a_r, b_r;
  logic        op_r;
  logic [4:0]  rem;
  logic        far_r;

  // Operand classification
  logic [7:0]  exp_a_raw, exp_b_raw, eexp_a, eexp_b;
  logic [22:0] frac_a, frac_b;
  logic        hid_a, hid_b, sb;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic        swap, is_nan, is_inf, is_special;
  logic [7:0]  big_exp, small_exp, d;
  logic [26:0] mant_big, mant_small;
  logic [31:0] inf_val;

  always_comb begin
    exp_a_raw  = a_r[30:23];
    exp_b_raw  = b_r[30:23];
    frac_a     = a_r[22:0];
    frac_b     = b_r[22:0];
    hid_a      = |exp_a_raw;
    hid_b      = |exp_b_raw;
    eexp_a     = hid_a ? exp_a_raw : 8'd1;
    eexp_b     = hid_b ? exp_b_raw : 8'd1;
    sb         = b_r[31] ^ op_r;
    nan_a      = (&exp_a_raw) & (|frac_a);
    nan_b      = (&exp_b_raw) & (|frac_b);
    inf_a      = (&exp_a_raw) & ~(|frac_a);
    inf_b      = (&exp_b_raw) & ~(|frac_b);
    // Equal magnitude keeps A in place so a's sign wins
    swap       = {eexp_b, frac_b} > {eexp_a, frac_a};
    big_exp    = swap ? eexp_b : eexp_a;
    small_exp  = swap ? eexp_a : eexp_b;
    d          = big_exp - small_exp;
    mant_big   = swap ? {hid_b, frac_b, 3'b000} : {hid_a, frac_a, 3'b000};
    mant_small = swap ? {hid_a, frac_a, 3'b000} : {hid_b, frac_b, 3'b000};
    is_nan     = nan_a | nan_b | (inf_a & inf_b & (a_r[31] ^ sb));
    is_inf     = inf_a | inf_b;
    is_special = is_nan | is_inf;
    inf_val    = inf_a ? {a_r[31], 8'hFF, 23'b0} : {sb, 8'hFF, 23'b0};
  end

  // Alignment step with sticky accumulation
  logic [4:0]  s, rem_nxt;
  logic [26:0] lost_mask, shifted, mant_b_step;

  always_comb begin
    s           = (rem < STEP) ? rem : STEP;
    rem_nxt     = rem - s;
    lost_mask   = (27'd1 << s) - 27'd1;
    shifted     = mant_b >> s;
    mant_b_step = {shifted[26:1], shifted[0] | (|(mant_b & lost_mask)) | mant_b[0]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (in_valid) state_nxt = UNPACK;
      UNPACK: begin
        if (is_special || d == 8'd0) state_nxt = DONE;
        else                         state_nxt = ALIGN;
      end
      ALIGN:  if (far_r || rem_nxt == 5'd0) state_nxt = DONE;
      DONE:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r           <= '0;
      b_r           <= '0;
      op_r          <= 1'b0;
      rem           <= '0;
      far_r         <= 1'b0;
      exp_result    <= '0;
      mant_a        <= '0;
      mant_b        <= '0;
      sign_result   <= 1'b0;
      eff_sub       <= 1'b0;
      special       <= 1'b0;
      special_value <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op;
          end
        end
        UNPACK: begin
          exp_result    <= big_exp;
          mant_a        <= mant_big;
          mant_b        <= mant_small;
          sign_result   <= swap ? sb : a_r[31];
          eff_sub       <= a_r[31] ^ sb;
          special       <= is_special;
          special_value <= is_nan ? 32'h7FC00000 : (is_inf ? inf_val : 32'h0);
          far_r         <= (d >= 8'd27);
          rem           <= d[4:0];
        end
        ALIGN: begin
          // Beyond 27 positions everything collapses into sticky
          if (far_r) begin
            mant_b <= {26'b0, |mant_b};
          end else begin
            mant_b <= mant_b_step;
            rem    <= rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_unpack_align.sv
// Directed bench for fp_unpack_align: latency, alignment, specials, backpressure, reset.
module tb_fp_unpack_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  exp_result;
  logic [26:0] mant_a;
  logic [26:0] mant_b;
  logic        sign_result;
  logic        eff_sub;
  logic        special;
  logic [31:0] special_value;

  int tests = 0;
  int fails = 0;

  fp_unpack_align #(.SHIFT_STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .exp_result(exp_result), .mant_a(mant_a), .mant_b(mant_b),
    .sign_result(sign_result), .eff_sub(eff_sub), .special(special),
    .special_value(special_value)
  );

  always #5 clk = ~clk;

  // Accept one operation and return the number of edges after E0 until out_valid.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                        output int lat);
    @(negedge clk);
    a = va; b = vb; op = vop; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests++; if ({exp_result, mant_a, mant_b, sign_result, eff_sub, special, special_value} !== '0) begin
      fails++; $display("FAIL reset_outputs got exp=%h ma=%h mb=%h sv=%h want all 0", exp_result, mant_a, mant_b, special_value);
    end
  endtask

  task automatic test_equal();
    int lat;
    run_op(32'h3F800000, 32'h3F800000, 1'b0, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL eq_latency got %0d want 1", lat); end
    tests++; if (exp_result !== 8'h7F) begin fails++; $display("FAIL eq_exp got %h want 7f", exp_result); end
    tests++; if (mant_a !== 27'h4000000) begin fails++; $display("FAIL eq_mant_a got %h want 4000000", mant_a); end
    tests++; if (mant_b !== 27'h4000000) begin fails++; $display("FAIL eq_mant_b got %h want 4000000", mant_b); end
    tests++; if ({sign_result, eff_sub, special} !== 3'b000) begin
      fails++; $display("FAIL eq_flags got s=%0b e=%0b sp=%0b want 000", sign_result, eff_sub, special);
    end
    release_op();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL eq_release got ov=%0b ir=%0b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_half();
    int lat;
    run_op(32'h3F800000, 32'h3F000000, 1'b0, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL half_latency got %0d want 2", lat); end
    tests++; if (mant_b !== 27'h2000000) begin fails++; $display("FAIL half_mant_b got %h want 2000000", mant_b); end
    tests++; if (exp_result !== 8'h7F || mant_a !== 27'h4000000) begin
      fails++; $display("FAIL half_exp_ma got %h %h want 7f 4000000", exp_result, mant_a);
    end
    release_op();
  endtask

  task automatic test_sticky();
    int lat;
    run_op(32'h3F800000, 32'h33800001, 1'b0, lat);
    tests++; if (lat !== 7) begin fails++; $display("FAIL d24_latency got %0d want 7", lat); end
    tests++; if (mant_b !== 27'h0000005) begin fails++; $display("FAIL d24_mant_b got %h want 0000005", mant_b); end
    release_op();
    // d = 26: last in-range shift, bit 26 lands on sticky
    run_op(32'h3F800000, 32'h32800000, 1'b0, lat);
    tests++; if (lat !== 8) begin fails++; $display("FAIL d26_latency got %0d want 8", lat); end
    tests++; if (mant_b !== 27'h0000001) begin fails++; $display("FAIL d26_mant_b got %h want 0000001", mant_b); end
    release_op();
  endtask

  task automatic test_far();
    int lat;
    run_op(32'h3F800000, 32'h32000000, 1'b0, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL d27_latency got %0d want 2", lat); end
    tests++; if (mant_b !== 27'h0000001) begin fails++; $display("FAIL d27_mant_b got %h want 0000001", mant_b); end
    release_op();
    run_op(32'h3F800000, 32'h30000000, 1'b0, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL d31_latency got %0d want 2", lat); end
    tests++; if (mant_b !== 27'h0000001 || exp_result !== 8'h7F) begin
      fails++; $display("FAIL d31_out got mb=%h exp=%h want 0000001 7f", mant_b, exp_result);
    end
    release_op();
  endtask

  task automatic test_swap();
    int lat;
    run_op(32'h3F800000, 32'h3FC00000, 1'b1, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL swap_latency got %0d want 1", lat); end
    tests++; if (mant_a !== 27'h6000000 || mant_b !== 27'h4000000) begin
      fails++; $display("FAIL swap_mant got %h %h want 6000000 4000000", mant_a, mant_b);
    end
    tests++; if (exp_result !== 8'h7F || sign_result !== 1'b1 || eff_sub !== 1'b1) begin
      fails++; $display("FAIL swap_flags got exp=%h s=%0b e=%0b want 7f 1 1", exp_result, sign_result, eff_sub);
    end
    release_op();
  endtask

  task automatic test_zero();
    int lat;
    run_op(32'h00000000, 32'h00000000, 1'b0, lat);
    tests++; if (lat !== 1 || special !== 1'b0) begin
      fails++; $display("FAIL zero_lat_special got %0d %0b want 1 0", lat, special);
    end
    tests++; if (exp_result !== 8'h01 || mant_a !== 27'h0 || mant_b !== 27'h0) begin
      fails++; $display("FAIL zero_out got exp=%h ma=%h mb=%h want 01 0 0", exp_result, mant_a, mant_b);
    end
    release_op();
  endtask

  task automatic test_special();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic        vo [5];
    logic [31:0] exp_v [5];
    int lat;
    va = '{32'h7F800000, 32'h7F800001, 32'h7F800000, 32'h3F800000, 32'h7F800000};
    vb = '{32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7F800000};
    vo = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_v = '{32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h7F800000};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vo[i], lat);
      tests++; if (lat !== 1 || special !== 1'b1) begin
        fails++; $display("FAIL special%0d_lat got lat=%0d sp=%0b want 1 1", i, lat, special);
      end
      tests++; if (special_value !== exp_v[i]) begin
        fails++; $display("FAIL special%0d_value got %h want %h", i, special_value, exp_v[i]);
      end
      release_op();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(32'h3F800000, 32'h3F000000, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 32'h40000000; b = 32'h40000000; in_valid = 1'b1;
      @(posedge clk);
      #1;
      tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++; $display("FAIL bp%0d_hs got ov=%0b ir=%0b want 1 0", i, out_valid, in_ready);
      end
      tests++; if (mant_b !== 27'h2000000 || mant_a !== 27'h4000000 || exp_result !== 8'h7F) begin
        fails++; $display("FAIL bp%0d_hold got ma=%h mb=%h exp=%h want 4000000 2000000 7f", i, mant_a, mant_b, exp_result);
      end
    end
    release_op();
    @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_idle got ir=%0b ov=%0b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_align();
    @(negedge clk);
    a = 32'h3F800000; b = 32'h33800001; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rst_align_hs got ir=%0b ov=%0b want 1 0", in_ready, out_valid);
    end
    tests++; if ({exp_result, mant_a, mant_b, special} !== '0) begin
      fails++; $display("FAIL rst_align_out got exp=%h ma=%h mb=%h want 0", exp_result, mant_a, mant_b);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(32'h3F800000, 32'h3F800000, 1'b0, lat);
    tests++; if (lat !== 1 || mant_b !== 27'h4000000 || exp_result !== 8'h7F) begin
      fails++; $display("FAIL b2b_first got lat=%0d mb=%h exp=%h want 1 4000000 7f", lat, mant_b, exp_result);
    end
    release_op();
    run_op(32'h3F800000, 32'h3F000000, 1'b0, lat);
    tests++; if (lat !== 2 || mant_b !== 27'h2000000) begin
      fails++; $display("FAIL b2b_second got lat=%0d mb=%h want 2 2000000", lat, mant_b);
    end
    release_op();
  endtask

  initial begin
    test_reset();
    test_equal();
    test_half();
    test_sticky();
    test_far();
    test_swap();
    test_zero();
    test_special();
    test_backpressure();
    test_reset_mid_align();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_unpack_align.md
Name: fp_unpack_align

Overview:
- Front-end of the FP add/sub datapath. Takes two IEEE 754 single-precision operands and an add/sub opcode.
- Unpacks each operand and classifies special values.
- Orders the operands by magnitude and right-aligns the smaller mantissa with guard/round/sticky bits, using an iterative multi-cycle shifter.
- Outputs the aligned 27-bit magnitudes and the common exponent for the adder, whose result goes on to normalization and rounding.

Parameters:
- SHIFT_STEP, 4, max alignment shift per ALIGN cycle (1..27).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  32  IEEE 754 operand A
- b  in  32  IEEE 754 operand B
- op  in  1  0 = A+B, 1 = A-B
- out_valid  out  1  outputs valid
- out_ready  in  1  consumer accepts outputs
- exp_result  out  8  larger effective exponent (biased)
- mant_a  out  27  larger-magnitude mantissa: [26] hidden, [25:3] fraction, [2:0] = 0
- mant_b  out  27  aligned smaller mantissa: [26:3] shifted value, [2] guard, [1] round, [0] sticky
- sign_result  out  1  sign of larger-magnitude operand (after op applied to B)
- eff_sub  out  1  signs differ after op applied; adder must subtract
- special  out  1  special_value is final, bypass adder
- special_value  out  32  final IEEE result when special = 1

Behaviour:
- Reset (sync, rst = 1 at posedge): state IDLE, in_ready = 1, out_valid = 0, all data outputs 0. Takes priority at any state, including mid-ALIGN; partial work is discarded.
- in_ready = 1 only in IDLE. Accept on posedge with in_valid && in_ready (acceptance edge E0); register a, b, op → UNPACK.
- UNPACK, one cycle:
  - sB = b[31] ^ op.
  - Exponent 0 (zero/denormal): hidden = 0, effective exponent = 1. Otherwise hidden = 1, effective exponent = raw exponent.
  - Swap so the operand with the larger {eff_exp, fraction} is A. On equal magnitude there is no swap; A keeps a's sign.
  - d = expA − expB (unsigned, 0..254).
  - Register exp_result, sign_result, eff_sub, mant_a, and the unshifted mant_b.
- Specials, checked in UNPACK and taking priority: special = 1, go to DONE, no ALIGN.
  - Either operand NaN (exp 0xFF, frac ≠ 0), or inf with inf and eff_sub = 1: special_value = 0x7FC00000.
  - Otherwise any inf: special_value = {sign of that inf after op, 0xFF, 23'b0}.
  - Zeros are not special; they take the normal path.
- Transitions out of UNPACK:
  - d = 0 → DONE.
  - d ≥ 27 → ALIGN for exactly one cycle: mant_b = {26'b0, OR of all mant_b bits}.
  - Otherwise ALIGN with remaining count rem = d.
- ALIGN, each cycle:
  - s = min(rem, SHIFT_STEP).
  - mant_b = (mant_b >> s) with bit 0 = OR(bits shifted out, old bit 0). Sticky is never cleared.
  - rem −= s. When rem reaches 0 → DONE.
- Latency: out_valid rises after posedge E0 + 1 + A, where:
  - A = 0 for special or d = 0;
  - A = 1 for d ≥ 27;
  - A = ceil(d / SHIFT_STEP) otherwise.
- DONE: out_valid = 1. All outputs held stable until out_valid && out_ready, then → IDLE; out_valid drops next cycle.
- No new input is accepted in the same cycle as the output handshake (in_ready rises in IDLE only). Throughput is one operation per L + 1 cycles minimum.
- Data outputs hold their last value in IDLE. special = 0 on every non-special result.

Test Plan:
- 1.0 + 1.0 (a = b = 0x3F800000, op = 0): out_valid after E0+1, exp_result = 0x7F, mant_a = mant_b = 0x4000000, eff_sub = 0, sign_result = 0, special = 0.
- 1.0 + 0.5 (b = 0x3F000000), SHIFT_STEP = 4: d = 1, out_valid after E0+2, mant_b = 0x2000000, exp_result = 0x7F.
- a = 0x3F800000, b = 0x33800001, op = 0: d = 24, 6 ALIGN cycles, out_valid after E0+7, mant_b = 0x0000005 (guard = 1, sticky = 1 from the lost LSB).
- 1.0 − 1.5 (b = 0x3FC00000, op = 1): swap; mant_a = 0x6000000, mant_b = 0x4000000, exp_result = 0x7F, sign_result = 1, eff_sub = 1.
- inf − inf (a = b = 0x7F800000, op = 1): special = 1, special_value = 0x7FC00000, out_valid after E0+1. Also a = 0x7F800001 with any b gives 0x7FC00000.
- Backpressure and reset:
  - Hold out_ready = 0 for 5 cycles in DONE: outputs stable, in_ready = 0, in_valid ignored.
  - Assert rst during ALIGN of the d = 24 case: next cycle IDLE, in_ready = 1, out_valid = 0, outputs 0.
  - A following 1.0 + 1.0 completes correctly.
